// File: rtl/udp_oe_csr_nchan.sv
// CSR block for a multi-channel UDP offload engine: DFH/ID header, common
// network configuration, and per-channel reset/status/control/packet counters.
module udp_oe_csr_nchan #(
   parameter int NUM_CHAN          = 2,
   parameter int MMIO64_ADDR_WIDTH = 8,
   parameter int MMIO64_DATA_WIDTH = 64,
   parameter int RST_PULSE_CYCLES  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [MMIO64_ADDR_WIDTH-1:0]  wr_addr,
   input  logic [MMIO64_DATA_WIDTH-1:0]  wr_data,
   input  logic                          rd_en,
   input  logic [MMIO64_ADDR_WIDTH-1:0]  rd_addr,
   output logic                          rd_valid,
   output logic [MMIO64_DATA_WIDTH-1:0]  rd_data,
   output logic [47:0]                   fpga_mac,
   output logic [31:0]                   fpga_ip,
   output logic [15:0]                   fpga_udp_port,
   output logic [31:0]                   fpga_netmask,
   output logic [47:0]                   host_mac,
   output logic [31:0]                   host_ip,
   output logic [15:0]                   host_udp_port,
   output logic [15:0]                   payload_per_packet,
   output logic [15:0]                   checksum_ip,
   output logic [NUM_CHAN-1:0]           chan_reset,
   output logic [NUM_CHAN*32-1:0]        misc_ctrl,
   input  logic [NUM_CHAN-1:0]           tx_pkt_stb,
   input  logic [NUM_CHAN-1:0]           rx_pkt_stb,
   input  logic [NUM_CHAN*8-1:0]         err_stb,
   input  logic [NUM_CHAN*16-1:0]        live_status
);

   localparam int AW = MMIO64_ADDR_WIDTH;

   localparam logic [63:0] DFH_WORD = {4'h2, 8'h01, 11'd0, 1'b0, 24'h003800, 4'h0, 12'h000};
   localparam logic [63:0] ID_LO    = 64'h966D_1F07_871D_4396;
   localparam logic [63:0] ID_HI    = 64'h9C85_60C5_729F_F873;
   localparam logic [63:0] REG_INFO = {32'd512, 1'b0, 15'd0, 16'd0};
   localparam logic [63:0] BAD_WORD = 64'h0BAD_0ADD_0BAD_0ADD;

   logic [63:0]                scratch;
   logic [NUM_CHAN-1:0][63:0]  ch_rd;
   logic [MMIO64_DATA_WIDTH-1:0] rd_mux;

   // Common configuration registers; fields are right-justified in the word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scratch            <= '0;
         fpga_mac           <= '0;
         fpga_ip            <= '0;
         fpga_udp_port      <= '0;
         fpga_netmask       <= '0;
         host_mac           <= '0;
         host_ip            <= '0;
         host_udp_port      <= '0;
         payload_per_packet <= '0;
         checksum_ip        <= '0;
      end else if (wr_en) begin
         case (wr_addr)
            AW'('h10): scratch            <= wr_data;
            AW'('h12): fpga_mac           <= wr_data[47:0];
            AW'('h13): fpga_ip            <= wr_data[31:0];
            AW'('h14): fpga_udp_port      <= wr_data[15:0];
            AW'('h15): fpga_netmask       <= wr_data[31:0];
            AW'('h16): host_mac           <= wr_data[47:0];
            AW'('h17): host_ip            <= wr_data[31:0];
            AW'('h18): host_udp_port      <= wr_data[15:0];
            AW'('h19): payload_per_packet <= wr_data[15:0];
            AW'('h1A): checksum_ip        <= wr_data[15:0];
            default: ;
         endcase
      end
   end

   for (genvar c = 0; c < NUM_CHAN; c++) begin : gen_chan
      localparam logic [AW-5:0] BLK = (AW-4)'(c + 2);

      logic        wr_blk;
      logic        hold;
      logic [7:0]  pulse_cnt;
      logic [7:0]  sticky;
      logic [31:0] misc;
      logic [31:0] tx_cnt;
      logic [31:0] rx_cnt;
      logic [63:0] rd_word;

      assign wr_blk        = wr_en && (wr_addr[AW-1:4] == BLK);
      assign chan_reset[c] = (pulse_cnt != 8'd0);
      // A starting pulse already zeroes state so the channel is clean on its first reset cycle
      assign hold          = chan_reset[c] || (wr_blk && wr_addr[3:0] == 4'h1 && wr_data[0]);
      assign misc_ctrl[c*32 +: 32] = misc;
      assign ch_rd[c]      = rd_word;

      // Reset pulse down-counter; a bit0 write (re)loads the full length
      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            pulse_cnt <= '0;
         else if (wr_blk && wr_addr[3:0] == 4'h1 && wr_data[0])
            pulse_cnt <= 8'(RST_PULSE_CYCLES);
         else if (pulse_cnt != 8'd0)
            pulse_cnt <= pulse_cnt - 8'd1;
      end

      // Sticky error bits: new errors win over a simultaneous write-1-to-clear
      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            sticky <= '0;
         else if (hold)
            sticky <= '0;
         else
            sticky <= (sticky & ~((wr_blk && wr_addr[3:0] == 4'h2) ? wr_data[7:0] : 8'h00))
                      | err_stb[c*8 +: 8];
      end

      // Channel control word, unaffected by the channel reset pulse
      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            misc <= '0;
         else if (wr_blk && wr_addr[3:0] == 4'h3)
            misc <= wr_data[31:0];
      end

      // Saturating tx packet counter; a write clears it and beats a coincident strobe
      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            tx_cnt <= '0;
         else if (hold || (wr_blk && wr_addr[3:0] == 4'h4))
            tx_cnt <= '0;
         else if (tx_pkt_stb[c] && tx_cnt != 32'hFFFF_FFFF)
            tx_cnt <= tx_cnt + 32'd1;
      end

      // Saturating rx packet counter, same clear rules as tx
      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            rx_cnt <= '0;
         else if (hold || (wr_blk && wr_addr[3:0] == 4'h5))
            rx_cnt <= '0;
         else if (rx_pkt_stb[c] && rx_cnt != 32'hFFFF_FFFF)
            rx_cnt <= rx_cnt + 32'd1;
      end

      // Per-channel read word selected by register offset
      always_comb begin
         rd_word = BAD_WORD;
         case (rd_addr[3:0])
            4'h0: rd_word = {48'd0, 8'(c), 8'(NUM_CHAN)};
            4'h1: rd_word = {63'd0, chan_reset[c]};
            4'h2: rd_word = {32'd0, live_status[c*16 +: 16], 8'd0, sticky};
            4'h3: rd_word = {32'd0, misc};
            4'h4: rd_word = {32'd0, tx_cnt};
            4'h5: rd_word = {32'd0, rx_cnt};
            default: rd_word = BAD_WORD;
         endcase
      end
   end

   // Read decode across header, common and channel blocks
   always_comb begin
      rd_mux = BAD_WORD;
      case (rd_addr)
         AW'('h00): rd_mux = DFH_WORD;
         AW'('h01): rd_mux = ID_LO;
         AW'('h02): rd_mux = ID_HI;
         AW'('h03): rd_mux = 64'd0;
         AW'('h04): rd_mux = REG_INFO;
         AW'('h10): rd_mux = scratch;
         AW'('h11): rd_mux = 64'(NUM_CHAN);
         AW'('h12): rd_mux = 64'(fpga_mac);
         AW'('h13): rd_mux = 64'(fpga_ip);
         AW'('h14): rd_mux = 64'(fpga_udp_port);
         AW'('h15): rd_mux = 64'(fpga_netmask);
         AW'('h16): rd_mux = 64'(host_mac);
         AW'('h17): rd_mux = 64'(host_ip);
         AW'('h18): rd_mux = 64'(host_udp_port);
         AW'('h19): rd_mux = 64'(payload_per_packet);
         AW'('h1A): rd_mux = 64'(checksum_ip);
         default: ;
      endcase
      for (int c = 0; c < NUM_CHAN; c++) begin
         if (rd_addr[AW-1:4] == (AW-4)'(c + 2))
            rd_mux = ch_rd[c];
      end
   end

   // One-cycle read response; data holds until the next read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en)
            rd_data <= rd_mux;
      end
   end

endmodule

// File: tb/tb_udp_oe_csr_nchan.sv
// Scoreboard bench for udp_oe_csr_nchan: reads push expected words, a monitor
// pops and compares whenever rd_valid is presented.
module tb_udp_oe_csr_nchan;

   localparam logic [63:0] BAD = 64'h0BAD_0ADD_0BAD_0ADD;
   localparam logic [63:0] DFH = {4'h2, 8'h01, 11'd0, 1'b0, 24'h003800, 4'h0, 12'h000};

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic        rd_valid;
   logic [63:0] rd_data;
   logic [47:0] fpga_mac;
   logic [31:0] fpga_ip;
   logic [15:0] fpga_udp_port;
   logic [31:0] fpga_netmask;
   logic [47:0] host_mac;
   logic [31:0] host_ip;
   logic [15:0] host_udp_port;
   logic [15:0] payload_per_packet;
   logic [15:0] checksum_ip;
   logic [1:0]  chan_reset;
   logic [63:0] misc_ctrl;
   logic [1:0]  tx_pkt_stb;
   logic [1:0]  rx_pkt_stb;
   logic [15:0] err_stb;
   logic [31:0] live_status;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [63:0] exp_q[$];
   string       name_q[$];
   logic        mon_pend;

   udp_oe_csr_nchan #(
      .NUM_CHAN(2), .MMIO64_ADDR_WIDTH(8), .MMIO64_DATA_WIDTH(64), .RST_PULSE_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .fpga_mac(fpga_mac), .fpga_ip(fpga_ip), .fpga_udp_port(fpga_udp_port),
      .fpga_netmask(fpga_netmask), .host_mac(host_mac), .host_ip(host_ip),
      .host_udp_port(host_udp_port), .payload_per_packet(payload_per_packet),
      .checksum_ip(checksum_ip), .chan_reset(chan_reset), .misc_ctrl(misc_ctrl),
      .tx_pkt_stb(tx_pkt_stb), .rx_pkt_stb(rx_pkt_stb), .err_stb(err_stb),
      .live_status(live_status)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue a read (caller is at a negedge); expected word goes to the scoreboard
   task automatic rd(input logic [7:0] a, input logic [63:0] exp, input string name);
      rd_en   = 1'b1;
      rd_addr = a;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [63:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Monitor: rd_valid must follow rd_en by one cycle; responses pop the scoreboard
   always @(posedge clk) begin
      mon_pend = rd_en && !reset;
      #1;
      check("rd_valid_timing", 64'(rd_valid), 64'(mon_pend));
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rd_valid: got data %h, expected no response", rd_data);
         end else begin
            check(name_q.pop_front(), rd_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int high;
      int bad0;
      reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
      tx_pkt_stb = 0; rx_pkt_stb = 0; err_stb = 0;
      live_status = {16'hABCD, 16'h1234};
      repeat (3) @(negedge clk);
      check("rst_rd_data", rd_data, 64'd0);
      check("rst_chan_reset", 64'(chan_reset), 64'd0);
      check("rst_misc_ctrl", misc_ctrl, 64'd0);
      check("rst_fpga_mac", 64'(fpga_mac), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Header and identification
      rd(8'h00, DFH, "dfh");
      rd(8'h01, 64'h966D_1F07_871D_4396, "id_lo");
      rd(8'h02, 64'h9C85_60C5_729F_F873, "id_hi");
      rd(8'h03, 64'd0, "reg_offset");
      rd(8'h04, 64'h0000_0200_0000_0000, "reg_info");
      rd(8'h11, 64'd2, "num_chan");
      rd(8'h05, BAD, "unmapped_05");
      rd(8'h1B, BAD, "unmapped_1b");

      // Common configuration
      wr(8'h12, 64'hFFFF_AABB_CCDD_EEFF);
      check("fpga_mac_out", 64'(fpga_mac), 64'h0000_AABB_CCDD_EEFF);
      rd(8'h12, 64'h0000_AABB_CCDD_EEFF, "fpga_mac_rd");
      rd(8'h80, BAD, "unmapped_ch6");
      rd(8'h40, BAD, "unmapped_ch2");
      wr(8'h13, 64'hFFFF_FFFF_1234_5678);
      check("fpga_ip_out", 64'(fpga_ip), 64'h1234_5678);
      rd(8'h13, 64'h1234_5678, "fpga_ip_rd");
      wr(8'h1A, 64'hFFFF_FFFF_FFFF_BEEF);
      check("checksum_ip_out", 64'(checksum_ip), 64'hBEEF);
      wr(8'h11, 64'h55);
      rd(8'h11, 64'd2, "num_chan_ro");
      wr(8'h10, 64'h0123_4567_89AB_CDEF);
      // Same-cycle read and write returns the old value
      wr_en = 1; wr_addr = 8'h10; wr_data = 64'hFEDC_BA98_7654_3210;
      rd(8'h10, 64'h0123_4567_89AB_CDEF, "rdwr_pre_value");
      wr_en = 0;
      rd(8'h10, 64'hFEDC_BA98_7654_3210, "scratch_new");

      // Channel info and control
      rd(8'h20, 64'h0002, "ch0_info");
      rd(8'h30, 64'h0102, "ch1_info");
      wr(8'h33, 64'hFFFF_FFFF_CAFE_F00D);
      check("misc_ctrl_out", misc_ctrl, 64'hCAFE_F00D_0000_0000);
      rd(8'h33, 64'h0000_0000_CAFE_F00D, "ch1_misc_rd");
      rd(8'h36, BAD, "ch1_unused_off");

      // Reset pulse on ch1 with restart after 10 high cycles
      wr(8'h31, 64'd1);
      high = 0;
      bad0 = 0;
      for (int i = 0; i < 40; i++) begin
         if (chan_reset[1]) high++;
         if (chan_reset[0]) bad0++;
         wr_en   = (i == 9);
         wr_addr = 8'h31;
         wr_data = 64'd1;
         rd_en   = (i == 3);
         rd_addr = 8'h31;
         if (i == 3) begin
            exp_q.push_back(64'd1);
            name_q.push_back("ch1_reset_rd_active");
         end
         @(negedge clk);
      end
      wr_en = 0; rd_en = 0;
      check("ch1_pulse_len", 64'(high), 64'd26);
      check("ch0_no_pulse", 64'(bad0), 64'd0);
      rd(8'h31, 64'd0, "ch1_reset_rd_idle");
      wr(8'h31, 64'hFE);
      check("bit0_zero_ignored", 64'(chan_reset), 64'd0);

      // Packet counters
      for (int i = 0; i < 5; i++) begin
         tx_pkt_stb = 2'b01; @(negedge clk);
         tx_pkt_stb = 2'b00; @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         rx_pkt_stb = 2'b10; @(negedge clk);
         rx_pkt_stb = 2'b00;
      end
      rd(8'h24, 64'd5, "ch0_tx_5");
      rd(8'h25, 64'd0, "ch0_rx_0");
      rd(8'h35, 64'd3, "ch1_rx_3");
      wr_en = 1; wr_addr = 8'h24; wr_data = 64'd0; tx_pkt_stb = 2'b01;
      @(negedge clk);
      wr_en = 0; tx_pkt_stb = 2'b00;
      rd(8'h24, 64'd0, "ch0_tx_clear_vs_stb");
      force dut.gen_chan[0].tx_cnt = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.gen_chan[0].tx_cnt;
      tx_pkt_stb = 2'b01; @(negedge clk);
      tx_pkt_stb = 2'b00;
      rd(8'h24, 64'hFFFF_FFFF, "ch0_tx_saturate");

      // Sticky error bits
      err_stb = 16'h0005; @(negedge clk);
      err_stb = 16'h0000;
      rd(8'h22, 64'h0000_0000_1234_0005, "ch0_status_set");
      rd(8'h32, 64'h0000_0000_ABCD_0000, "ch1_status_clean");
      wr_en = 1; wr_addr = 8'h22; wr_data = 64'h01; err_stb = 16'h0001;
      @(negedge clk);
      wr_en = 0; err_stb = 16'h0000;
      rd(8'h22, 64'h0000_0000_1234_0005, "ch0_status_set_wins");
      wr(8'h22, 64'h05);
      rd(8'h22, 64'h0000_0000_1234_0000, "ch0_status_cleared");
      err_stb = 16'h0080; @(negedge clk);
      err_stb = 16'h0000;

      // Reset in the middle of a pulse and a read
      wr(8'h31, 64'd1);
      @(negedge clk);
      rd_en = 1; rd_addr = 8'h10;
      exp_q.push_back(64'hFEDC_BA98_7654_3210);
      name_q.push_back("inflight_read");
      @(posedge clk);
      #2;
      rd_en = 0;
      reset = 1'b1;
      #1;
      check("rst_drop_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_drop_chan_reset", 64'(chan_reset), 64'd0);
      check("rst_drop_rd_data", rd_data, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_misc", misc_ctrl, 64'd0);
      check("post_rst_mac", 64'(fpga_mac), 64'd0);
      rd(8'h24, 64'd0, "post_rst_ch0_tx");
      rd(8'h35, 64'd0, "post_rst_ch1_rx");
      rd(8'h22, 64'h0000_0000_1234_0000, "post_rst_ch0_status");
      rd(8'h10, 64'd0, "post_rst_scratch");
      bad0 = 0;
      for (int i = 0; i < 20; i++) begin
         if (chan_reset != 2'b00) bad0++;
         @(negedge clk);
      end
      check("no_pulse_after_rst", 64'(bad0), 64'd0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
